// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory bus bundle for load_store_unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_load;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    // LSU side
    modport slave (
        input  req_valid, req_load, req_byte, req_addr, req_wdata,
        output req_ready, stall, rsp_valid, rsp_data, rsp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    // pipeline + memory environment side
    modport master (
        output req_valid, req_load, req_byte, req_addr, req_wdata,
        input  req_ready, stall, rsp_valid, rsp_data, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage with gnt/rvalid handshake; optional LSU_MISALIGN_CHECK_EN
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_next;
    logic        l_load, l_byte;
    logic [31:0] l_addr, l_wdata;
    logic [7:0]  cnt;
    logic        misalign, timeout_hit;
    logic [7:0]  lane_byte;
    logic [31:0] load_fmt;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = !bus.req_byte && (bus.req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // counter has already seen cnt empty WAIT cycles; this one makes TIMEOUT_CYCLES
    assign timeout_hit = (state == WAIT) && !bus.mem_rvalid
                         && ((cnt + 8'd1) == 8'(TIMEOUT_CYCLES));

    // pick the addressed byte lane (little-endian) and sign-extend for byte loads
    always_comb begin
        lane_byte = bus.mem_rdata[7:0];
        unique case (l_addr[1:0])
            2'd0: lane_byte = bus.mem_rdata[7:0];
            2'd1: lane_byte = bus.mem_rdata[15:8];
            2'd2: lane_byte = bus.mem_rdata[23:16];
            2'd3: lane_byte = bus.mem_rdata[31:24];
            default: lane_byte = bus.mem_rdata[7:0];
        endcase
        load_fmt = l_byte ? {{24{lane_byte[7]}}, lane_byte} : bus.mem_rdata;
    end

    // state register; async reset drops mem_req immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // next state and all combinational outputs
    always_comb begin
        state_next     = state;
        bus.req_ready  = 1'b0;
        bus.stall      = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = 32'h0;
        bus.mem_wdata  = 32'h0;
        bus.mem_be     = 4'h0;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.stall     = bus.req_valid;
                if (bus.req_valid) state_next = misalign ? DONE : REQ;
            end
            REQ: begin
                bus.stall    = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_we   = !l_load;
                bus.mem_addr = {l_addr[31:2], 2'b00};
                if (l_load || !l_byte) bus.mem_be = 4'b1111;
                else                   bus.mem_be = 4'b0001 << l_addr[1:0];
                if (!l_load) bus.mem_wdata = l_byte ? {4{l_wdata[7:0]}} : l_wdata;
                if (bus.mem_gnt) state_next = l_load ? WAIT : DONE;
            end
            WAIT: begin
                bus.stall = 1'b1;
                if (bus.mem_rvalid || timeout_hit) state_next = DONE;
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // capture the request on acceptance so later pipeline changes cannot disturb it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_load  <= 1'b0;
            l_byte  <= 1'b0;
            l_addr  <= 32'h0;
            l_wdata <= 32'h0;
        end else if (state == IDLE && bus.req_valid) begin
            l_load  <= bus.req_load;
            l_byte  <= bus.req_byte;
            l_addr  <= bus.req_addr;
            l_wdata <= bus.req_wdata;
        end
    end

    // WAIT-cycle counter, restarted on the grant of a load
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            cnt <= 8'h0;
        else if (state == REQ && bus.mem_gnt) cnt <= 8'h0;
        else if (state == WAIT)               cnt <= cnt + 8'd1;
    end

    // response registers: loaded only on entry to DONE, zero in every other cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rsp_data <= 32'h0;
            bus.rsp_err  <= 1'b0;
        end else begin
            bus.rsp_data <= (state == WAIT && bus.mem_rvalid) ? load_fmt : 32'h0;
            bus.rsp_err  <= timeout_hit || (state == IDLE && bus.req_valid && misalign);
        end
    end
endmodule
